// File: rtl/mbs_syscall_unit.sv
// mbs_syscall_unit: services SYSCALL instructions from the MBScore core.
// The 20-bit code selects putchar (8N1 UART transmit), a timed delay or halt.
// The core is held in pause until the selected service has finished.
module mbs_syscall_unit #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DELAY_UNIT   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        syscall,
   input  logic [19:0] syscall_code,
   output logic        pause,
   output logic        uart_tx,
   output logic        halted,
   output logic        busy,
   output logic        bad_code
);

   // The +1 keeps the baud counter at least one bit wide when CLKS_PER_BIT is 1.
   localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
   // Wide enough for 255 * DELAY_UNIT without overflow.
   localparam int DLY_W = 8 + $clog2(DELAY_UNIT) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      DELAY,
      HALT
   } state_t;

   state_t              state;
   logic                armed;
   logic [7:0]          shift_reg;
   logic [2:0]          bit_cnt;
   logic [BAUD_W-1:0]   baud_cnt;
   logic [DLY_W-1:0]    delay_cnt;

   logic [3:0]          func;
   logic [7:0]          payload;
   logic                trig;
   logic                stall_func;
   logic [DLY_W-1:0]    delay_total;
   logic                unused_code_bits;

   assign func    = syscall_code[19:16];
   assign payload = syscall_code[7:0];
   assign unused_code_bits = ^syscall_code[15:8];

   // A syscall is serviced once per assertion, only from IDLE and never while reset is held.
   assign trig = syscall & armed & (state == IDLE) & ~rst;

   // Functions that hold the core already in their trigger cycle; a zero-length delay does not.
   always_comb begin
      stall_func = 1'b0;
      case (func)
         4'd0:    stall_func = 1'b1;
         4'd1:    stall_func = 1'b1;
         4'd2:    stall_func = (payload != 8'd0);
         default: stall_func = 1'b0;
      endcase
   end

   // Total delay length in clock cycles, counting the trigger cycle.
   assign delay_total = DLY_W'(payload) * DLY_W'(DELAY_UNIT);

   assign pause = (trig & stall_func) | (state != IDLE);
   assign busy  = (state != IDLE);

   // Main service FSM: trigger arming, UART framing, delay countdown and halt latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         armed     <= 1'b1;
         shift_reg <= 8'd0;
         bit_cnt   <= 3'd0;
         baud_cnt  <= '0;
         delay_cnt <= '0;
         uart_tx   <= 1'b1;
         halted    <= 1'b0;
         bad_code  <= 1'b0;
      end else begin
         bad_code <= 1'b0;

         if (trig) begin
            armed <= 1'b0;
         end else if (!syscall) begin
            armed <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (trig) begin
                  case (func)
                     4'd0: begin
                        shift_reg <= payload;
                        bit_cnt   <= 3'd0;
                        baud_cnt  <= '0;
                        uart_tx   <= 1'b0;
                        state     <= TX_START;
                     end
                     4'd1: begin
                        halted <= 1'b1;
                        state  <= HALT;
                     end
                     4'd2: begin
                        // A one-cycle delay is fully covered by the trigger cycle itself.
                        if (delay_total > DLY_W'(1)) begin
                           delay_cnt <= delay_total - DLY_W'(1);
                           state     <= DELAY;
                        end
                     end
                     default: begin
                        bad_code <= 1'b1;
                     end
                  endcase
               end
            end

            TX_START: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  uart_tx  <= shift_reg[0];
                  state    <= TX_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            TX_DATA: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= 3'd0;
                     uart_tx <= 1'b1;
                     state   <= TX_STOP;
                  end else begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     shift_reg <= shift_reg >> 1;
                     uart_tx   <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            TX_STOP: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            DELAY: begin
               if (delay_cnt <= DLY_W'(1)) begin
                  delay_cnt <= '0;
                  state     <= IDLE;
               end else begin
                  delay_cnt <= delay_cnt - DLY_W'(1);
               end
            end

            HALT: begin
               state <= HALT;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mbs_syscall_unit.sv
// Testbench for mbs_syscall_unit with small CLKS_PER_BIT and DELAY_UNIT.
// Expected waveforms come from arithmetic on the syscall code, not from the FSM.
module tb_mbs_syscall_unit;

   localparam int C  = 4;
   localparam int DU = 16;

   logic        clk;
   logic        rst;
   logic        syscall;
   logic [19:0] syscall_code;
   logic        pause;
   logic        uart_tx;
   logic        halted;
   logic        busy;
   logic        bad_code;

   int checks = 0;
   int errors = 0;

   mbs_syscall_unit #(
      .CLKS_PER_BIT(C),
      .DELAY_UNIT  (DU)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .syscall     (syscall),
      .syscall_code(syscall_code),
      .pause       (pause),
      .uart_tx     (uart_tx),
      .halted      (halted),
      .busy        (busy),
      .bad_code    (bad_code)
   );

   // Free-running 100 MHz-style clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Number of cycles pause should stay high, counting the trigger cycle.
   function automatic int exp_pause_len(input logic [19:0] code);
      int f;
      int p;
      f = int'(code[19:16]);
      p = int'(code[7:0]);
      if (f == 0) return 1 + 10 * C;
      if (f == 2) return p * DU;
      return 0;
   endfunction

   // Expected line level n cycles after the trigger of a putchar of byte d.
   function automatic logic exp_tx(input int n, input logic [7:0] d);
      int idx;
      if (n < 1 || n > 10 * C) return 1'b1;
      idx = (n - 1) / C;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      return 1'b1;
   endfunction

   // Issues one syscall, keeps syscall high for the whole window with scrambled
   // code bits, checks every cycle, then drops syscall for one cycle.
   task automatic applyStimulus(input logic [19:0] code, input int extra);
      int plen;
      int win;
      int pc;
      logic [3:0] f;
      f    = code[19:16];
      plen = exp_pause_len(code);
      win  = plen + extra;
      pc   = 0;
      for (int n = 0; n < win; n++) begin
         @(posedge clk);
         #1;
         syscall      = 1'b1;
         syscall_code = (n == 0) ? code : 20'($urandom);
         @(negedge clk);
         if (pause) pc++;
         checkOutput($sformatf("pause %05h n=%0d", code, n), 32'(pause), 32'(n < plen));
         checkOutput($sformatf("tx %05h n=%0d", code, n), 32'(uart_tx),
                     32'((f == 4'd0) ? exp_tx(n, code[7:0]) : 1'b1));
         checkOutput($sformatf("busy %05h n=%0d", code, n), 32'(busy), 32'(n >= 1 && n < plen));
         checkOutput($sformatf("bad %05h n=%0d", code, n), 32'(bad_code), 32'(f >= 4'd3 && n == 1));
         checkOutput($sformatf("halted %05h n=%0d", code, n), 32'(halted), 32'(0));
      end
      checkOutput($sformatf("pause_len %05h", code), 32'(pc), 32'(plen));
      @(posedge clk);
      #1;
      syscall      = 1'b0;
      syscall_code = 20'($urandom);
      @(negedge clk);
      checkOutput("drop pause", 32'(pause), 32'(0));
      checkOutput("drop busy", 32'(busy), 32'(0));
   endtask

   // Directed scenarios followed by a randomized mix of functions.
   initial begin
      logic [19:0] code;
      int sel;

      rst          = 1'b1;
      syscall      = 1'b1;
      syscall_code = 20'h00041;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rst tx", 32'(uart_tx), 32'(1));
         checkOutput("rst pause", 32'(pause), 32'(0));
         checkOutput("rst halted", 32'(halted), 32'(0));
         checkOutput("rst bad", 32'(bad_code), 32'(0));
         checkOutput("rst busy", 32'(busy), 32'(0));
      end
      @(posedge clk);
      #1;
      rst     = 1'b0;
      syscall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("idle tx", 32'(uart_tx), 32'(1));
         checkOutput("idle pause", 32'(pause), 32'(0));
      end

      applyStimulus(20'h00041, 6);
      applyStimulus(20'h20003, 4);
      applyStimulus(20'h20000, 4);
      applyStimulus(20'h50000, 4);

      // Abort a frame of 0x55 mid data bits with an asynchronous reset.
      for (int n = 0; n <= 10; n++) begin
         @(posedge clk);
         #1;
         syscall      = 1'b1;
         syscall_code = (n == 0) ? 20'h00055 : 20'($urandom);
         @(negedge clk);
      end
      checkOutput("abort pre tx", 32'(uart_tx), 32'(exp_tx(10, 8'h55)));
      #1;
      rst     = 1'b1;
      syscall = 1'b0;
      #1;
      checkOutput("abort tx", 32'(uart_tx), 32'(1));
      checkOutput("abort busy", 32'(busy), 32'(0));
      checkOutput("abort pause", 32'(pause), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back putchars with one low syscall cycle between them.
      applyStimulus(20'h00041, 0);
      applyStimulus(20'h0004A, 0);

      for (int k = 0; k < 12; k++) begin
         sel  = $urandom_range(0, 3);
         code = 20'($urandom);
         case (sel)
            0:       code[19:16] = 4'd0;
            1:       begin code[19:16] = 4'd2; code[7:0] = 8'($urandom_range(0, 4)); end
            2:       code[19:16] = 4'($urandom_range(3, 15));
            default: begin code[19:16] = 4'd2; code[7:0] = 8'd0; end
         endcase
         applyStimulus(code, 3);
      end

      // Halt holds the core until reset.
      for (int n = 0; n < 1010; n++) begin
         @(posedge clk);
         #1;
         syscall      = 1'b1;
         syscall_code = (n == 0) ? 20'h10000 : 20'($urandom);
         @(negedge clk);
         checkOutput($sformatf("halt pause n=%0d", n), 32'(pause), 32'(1));
         checkOutput($sformatf("halt halted n=%0d", n), 32'(halted), 32'(n >= 1));
      end
      #1;
      rst     = 1'b1;
      syscall = 1'b0;
      #1;
      checkOutput("halt rst halted", 32'(halted), 32'(0));
      checkOutput("halt rst pause", 32'(pause), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("final tx", 32'(uart_tx), 32'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
